// File: rtl/scaling_decompression.sv
// scaling_decompression: expands BETA-bit compressed words back to ALPHA bits
// y = ((x << (ALPHA-BETA)) + R - c) mod 2^ALPHA, streamed through a 2-stage pipe.
module scaling_decompression #(
    parameter int ALPHA  = 24,
    parameter int BETA   = 16,
    parameter int N_ELEM = 256,
    parameter int ROUND  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BETA-1:0]  s_data,
    input  logic             s_last,
    input  logic [ALPHA-1:0] c_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ALPHA-1:0] m_data,
    output logic             m_last,
    output logic             len_err
);

    localparam int SH = ALPHA - BETA;
    localparam int CW = $clog2(N_ELEM);
    localparam logic [ALPHA-1:0] RND =
        (ROUND != 0) ? (ALPHA'(1) << (SH - 1)) : '0;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_ELEM - 1);

    logic [CW-1:0]    r_cnt;
    logic [ALPHA-1:0] r_c_frame;
    logic             r_v1;
    logic [ALPHA-1:0] r_x1;
    logic [ALPHA-1:0] r_c1;
    logic             r_last1;
    logic             r_m_valid;
    logic [ALPHA-1:0] r_m_data;
    logic             r_m_last;
    logic             r_len_err;

    logic             w_adv;
    logic             w_acc;
    logic             w_first;
    logic             w_end;
    logic [ALPHA-1:0] w_x;

    assign w_adv   = !r_m_valid || m_ready;
    assign w_acc   = s_valid && w_adv;
    assign w_first = (r_cnt == '0);
    assign w_end   = (r_cnt == LAST_IDX);
    assign w_x     = {s_data, {SH{1'b0}}} + RND;

    assign s_ready = w_adv;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign len_err = r_len_err;

    // Frame position and the offset latched on each frame's first word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_c_frame <= '0;
        end else if (w_acc) begin
            if (w_first)
                r_c_frame <= c_in;
            if (w_end || s_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Stage 1: shift plus rounding offset, select the frame offset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_x1    <= '0;
            r_c1    <= '0;
            r_last1 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= s_valid;
            if (s_valid) begin
                r_x1    <= w_x;
                r_c1    <= w_first ? c_in : r_c_frame;
                r_last1 <= w_end || s_last;
            end
        end
    end

    // Stage 2: subtract the offset with wrap-around; hold while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_adv) begin
            r_m_valid <= r_v1;
            if (r_v1) begin
                r_m_data <= r_x1 - r_c1;
                r_m_last <= r_last1;
            end
        end
    end

    // Flag a word whose s_last disagrees with the expected frame end
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_len_err <= 1'b0;
        else
            r_len_err <= w_acc && (s_last != w_end);
    end

endmodule
